// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver. It synchronises the rx pin, qualifies the
// start bit at mid-bit, samples each data bit at its centre, checks the stop bit,
// and emits single-cycle byte/frame-error strobes for the receive FIFO.
//
// Handshake: valid is a one-cycle write strobe with no ready. The consumer (FIFO)
// must take data in that cycle or drop it; the receiver never stalls.
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic          rx_meta_q;
   logic          rx_s_q;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          frame_err_q;

   // Two-flop synchroniser; both flops reset high so the line reads idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receive FSM: bit timing, sampling, shift register and registered strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
               end
            end
            S_START: begin
               if (cnt_q == HALF_M1) begin
                  // A line that is high again at mid start bit was a glitch.
                  if (rx_s_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_DATA;
                     cnt_q   <= '0;
                     idx_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == FULL_M1) begin
                  // LSB arrives first, so shifting right leaves it in bit 0.
                  shift_q <= {rx_s_q, shift_q[7:1]};
                  cnt_q   <= '0;
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_STOP: begin
               if (cnt_q == FULL_M1) begin
                  if (rx_s_q) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_BREAK: begin
               // Wait out a held-low line so it reports only one framing error.
               if (rx_s_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: table of 8N1 frames with hand-computed outcomes,
// hand-written glitch / break / reset-mid-frame sequences, and random frames
// checked against a frame-level reference model through an event scoreboard.
module tb_uart_rx_frontend;

   localparam int CPB = 16;
   // rx driven at a negedge: 2 sync stages + 1 cycle to reach the FSM, then the
   // stop-bit sample point, then one cycle for the registered strobe.
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Scoreboard entry: {is_frame_err, expected data, expected cycle}.
   logic [40:0] exp_q[$];
   logic [7:0]  model_data;

   uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver: one 8N1 frame starting at the current negedge, then 'gap' idle cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap,
                             input logic exp_err, input logic [7:0] exp_data);
      exp_q.push_back({exp_err, exp_data, 32'(cyc + LAT)});
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      logic [40:0] e;
      if (!reset && (valid || frame_err)) begin
         if (valid && frame_err) chk("strobe_exclusive", 32'(valid & frame_err), 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h, no event expected (cycle %0d)",
                     valid, frame_err, data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", 32'(frame_err), 32'(e[40]));
            chk("strobe_data", 32'(data), 32'(e[39:32]));
            chk("strobe_cycle", 32'(cyc), e[31:0]);
         end
      end
   end

   typedef struct {
      logic [7:0] b;
      logic       stop_bit;
      int         gap;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [7:0] b;
      logic       ok;
      int         gap;

      vecs[0] = '{8'h55, 1'b1, 4, 1'b0, 8'h55};
      vecs[1] = '{8'hA3, 1'b1, 4, 1'b0, 8'hA3};
      vecs[2] = '{8'h3C, 1'b0, 4, 1'b1, 8'hA3};
      vecs[3] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
      vecs[5] = '{8'h81, 1'b1, 6, 1'b0, 8'h81};
      vecs[6] = '{8'hC3, 1'b0, 3, 1'b1, 8'h81};
      vecs[7] = '{8'h5A, 1'b1, 2, 1'b0, 8'h5A};

      // Reset: outputs must be clear while reset is held.
      reset = 1'b1;
      rx    = 1'b1;
      #1;
      chk("reset_data", 32'(data), 32'h00);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_frame_err", 32'(frame_err), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_data = 8'h00;
      repeat (4) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Table-driven frames: good bytes, framing errors, back-to-back.
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].b, vecs[i].stop_bit, vecs[i].gap, vecs[i].exp_err, vecs[i].exp_data);
         if (!vecs[i].exp_err) model_data = vecs[i].exp_data;
      end
      repeat (20) @(negedge clk);

      // Framing error: busy stays up until the line returns high.
      send_frame(8'h3C, 1'b0, 0, 1'b1, model_data);
      chk("ferr_busy_held", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      chk("ferr_busy_released", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);

      // Glitch shorter than half a bit: busy blips, nothing else happens.
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      chk("glitch_busy_high", 32'(busy), 32'd1);
      repeat (10) @(negedge clk);
      chk("glitch_busy_low", 32'(busy), 32'd0);
      chk("glitch_data_kept", 32'(data), 32'(model_data));
      repeat (4) @(negedge clk);

      // Break: 40 bit times low gives exactly one frame error.
      exp_q.push_back({1'b1, model_data, 32'(cyc + LAT)});
      rx = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      chk("break_busy_mid", 32'(busy), 32'd1);
      repeat (20 * CPB) @(negedge clk);
      chk("break_busy_end", 32'(busy), 32'd1);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("break_busy_released", 32'(busy), 32'd0);
      send_frame(8'h7E, 1'b1, 4, 1'b0, 8'h7E);
      model_data = 8'h7E;

      // Reset mid-frame: 0xF0 aborted after data bit 3.
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b = 8'hF0;
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      chk("midframe_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      rx    = 1'b1;
      #1;
      chk("midreset_data", 32'(data), 32'h00);
      chk("midreset_valid", 32'(valid), 32'd0);
      chk("midreset_frame_err", 32'(frame_err), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_data = 8'h00;
      repeat (3) @(negedge clk);
      send_frame(8'h12, 1'b1, 4, 1'b0, 8'h12);
      model_data = 8'h12;

      // Random frames against the frame-level model: a good stop bit delivers
      // the byte; a bad one reports an error and keeps the last good byte.
      for (int i = 0; i < 30; i++) begin
         b   = 8'($urandom_range(0, 255));
         ok  = ($urandom_range(0, 3) != 0);
         gap = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12));
         if (ok) begin
            send_frame(b, 1'b1, gap, 1'b0, b);
            model_data = b;
         end else begin
            send_frame(b, 1'b0, gap, 1'b1, model_data);
         end
      end

      repeat (LAT + 20) @(negedge clk);
      chk("all_events_seen", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: the stimulus is cycle-bounded, this only guards against a stuck run.
   initial begin
      #2000000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
